// File: rtl/bp_zynq_cfg_reporter.sv
// bp_zynq_cfg_reporter
//   Captures the flattened BlackParrot configuration vector on request and
//   streams it to the PS shell as a framed sequence of 32b words:
//     header {magic_p, cfg_words_p[15:0]}, then cfg_words_p payload words.
//   Optional feature macro: BP_ZYNQ_CFG_REPORT_CHECKSUM_EN
//     When defined, a trailing word carries the XOR of every transferred
//     word of the frame (header plus payload).
//   The stream uses a valid->ready handshake. All stream outputs come from
//   registers and are forced low while reset_i is high.

module bp_zynq_cfg_reporter #(
  parameter int unsigned cfg_words_p  = 16,
  parameter int unsigned word_width_p = 32,
  parameter logic [15:0] magic_p      = 16'h0B9A
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [cfg_words_p*word_width_p-1:0] cfg_i,
  input  logic                                req_v_i,
  output logic                                req_ready_o,
  output logic [word_width_p-1:0]             data_o,
  output logic                                v_o,
  input  logic                                ready_i,
  output logic                                busy_o
);

  localparam int unsigned IdxW = (cfg_words_p > 1) ? $clog2(cfg_words_p) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(cfg_words_p - 1);
  localparam logic [word_width_p-1:0] HeaderWord =
    word_width_p'({magic_p, 16'(cfg_words_p)});

  typedef enum logic [1:0] {
    e_idle,
    e_header,
`ifdef BP_ZYNQ_CFG_REPORT_CHECKSUM_EN
    e_payload,
    e_checksum
`else
    e_payload
`endif
  } state_e;

  state_e                              state_q;
  logic [IdxW-1:0]                     idx_q;
  logic [IdxW-1:0]                     idx_d;
  logic [cfg_words_p*word_width_p-1:0] cfg_q;
  logic [word_width_p-1:0]             data_q;
  logic                                v_q;
  logic                                busy_q;
  logic                                req_ready_q;
`ifdef BP_ZYNQ_CFG_REPORT_CHECKSUM_EN
  logic [word_width_p-1:0]             xor_q;
`endif

  // Index of the payload word that follows the one currently presented.
  assign idx_d = idx_q + 1'b1;

  // Frame sequencer; the registered outputs are loaded with the values of the
  // state being entered, so every output is stable for the whole cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: the snapshot is an ordinary register bank, not a RAM, so clearing
    // it on reset is cheap and guarantees a reset discards stale config.
    if (reset_i) begin
      state_q     <= e_idle;
      idx_q       <= '0;
      cfg_q       <= '0;
      data_q      <= '0;
      v_q         <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
`ifdef BP_ZYNQ_CFG_REPORT_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of state_q, idx_q, data_q and cfg_q.
      case (state_q)
        e_idle: begin
          if (req_v_i) begin
            state_q     <= e_header;
            cfg_q       <= cfg_i;
            idx_q       <= '0;
            data_q      <= HeaderWord;
            v_q         <= 1'b1;
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
`ifdef BP_ZYNQ_CFG_REPORT_CHECKSUM_EN
            xor_q       <= '0;
`endif
          end
        end

        e_header: begin
          if (ready_i) begin
            state_q <= e_payload;
            data_q  <= cfg_q[word_width_p-1:0];
`ifdef BP_ZYNQ_CFG_REPORT_CHECKSUM_EN
            xor_q   <= xor_q ^ data_q;
`endif
          end
        end

        e_payload: begin
          if (ready_i) begin
`ifdef BP_ZYNQ_CFG_REPORT_CHECKSUM_EN
            xor_q <= xor_q ^ data_q;
`endif
            if (idx_q == LastIdx) begin
              idx_q <= '0;
`ifdef BP_ZYNQ_CFG_REPORT_CHECKSUM_EN
              // The checksum word already folds in the word leaving now.
              state_q <= e_checksum;
              data_q  <= xor_q ^ data_q;
`else
              state_q     <= e_idle;
              data_q      <= '0;
              v_q         <= 1'b0;
              busy_q      <= 1'b0;
              req_ready_q <= 1'b1;
`endif
            end else begin
              idx_q  <= idx_d;
              data_q <= cfg_q[word_width_p*int'(idx_d) +: word_width_p];
            end
          end
        end

`ifdef BP_ZYNQ_CFG_REPORT_CHECKSUM_EN
        e_checksum: begin
          if (ready_i) begin
            state_q     <= e_idle;
            data_q      <= '0;
            v_q         <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
`endif

        default: begin
          state_q     <= e_idle;
          idx_q       <= '0;
          data_q      <= '0;
          v_q         <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Reset silences the interface in the same cycle it is asserted, even if a
  // frame was in flight when it arrived.
  assign v_o         = v_q & ~reset_i;
  assign busy_o      = busy_q & ~reset_i;
  assign req_ready_o = req_ready_q & ~reset_i;
  assign data_o      = reset_i ? '0 : data_q;

endmodule

// File: tb/tb_bp_zynq_cfg_reporter.sv
// Directed bench for bp_zynq_cfg_reporter with cfg_words_p = 4.
// Follows BP_ZYNQ_CFG_REPORT_CHECKSUM_EN to decide whether a checksum word
// is expected at the end of every frame.

module tb_bp_zynq_cfg_reporter;

  localparam int N = 4;
  localparam logic [N*32-1:0] BaseCfg =
    {32'h88888888, 32'h44444444, 32'h22222222, 32'h11111111};

  logic           clk;
  logic           reset_i;
  logic [N*32-1:0] cfg_i;
  logic           req_v_i;
  logic           req_ready_o;
  logic [31:0]    data_o;
  logic           v_o;
  logic           ready_i;
  logic           busy_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  bp_zynq_cfg_reporter #(
    .cfg_words_p (N),
    .word_width_p(32),
    .magic_p     (16'h0B9A)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .cfg_i      (cfg_i),
    .req_v_i    (req_v_i),
    .req_ready_o(req_ready_o),
    .data_o     (data_o),
    .v_o        (v_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build the expected frame for a given configuration vector.
  task automatic make_exp(input logic [N*32-1:0] cfg);
    logic [31:0] x;
    exp_q.delete();
    exp_q.push_back(32'h0B9A0004);
    x = 32'h0B9A0004;
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(cfg[32*k +: 32]);
      x = x ^ cfg[32*k +: 32];
    end
`ifdef BP_ZYNQ_CFG_REPORT_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // Sink model: receives one frame, optionally applying backpressure with the
  // ready pattern 1,0,0,1,0,0,..., and checks hold-stability while stalled.
  task automatic collect(input string tag, input bit bp);
    logic [31:0] got[$];
    logic        prev_hold;
    logic [31:0] prev_data;
    int          cyc;
    prev_hold = 1'b0;
    prev_data = '0;
    cyc       = 0;
    while (got.size() < exp_q.size() && cyc < 200) begin
      if (prev_hold) begin
        check({tag, " hold v_o"}, 32'(v_o), 32'd1);
        check({tag, " hold data_o"}, data_o, prev_data);
      end
      ready_i = bp ? (cyc % 3 == 0) : 1'b1;
      if (v_o && ready_i) got.push_back(data_o);
      prev_hold = v_o && !ready_i;
      prev_data = data_o;
      cyc++;
      tick();
    end
    ready_i = 1'b1;
    check({tag, " word count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int k = 0; k < got.size() && k < exp_q.size(); k++)
      check($sformatf("%s word%0d", tag, k), got[k], exp_q[k]);
    if (!bp) check({tag, " cycles"}, 32'(cyc), 32'(exp_q.size()));
  endtask

  task automatic check_idle(input string tag);
    check({tag, " idle v_o"}, 32'(v_o), 32'd0);
    check({tag, " idle busy_o"}, 32'(busy_o), 32'd0);
    check({tag, " idle req_ready_o"}, 32'(req_ready_o), 32'd1);
    check({tag, " idle data_o"}, data_o, 32'd0);
  endtask

  initial begin
    reset_i = 1'b1;
    req_v_i = 1'b0;
    ready_i = 1'b1;
    cfg_i   = BaseCfg;

    // Reset state
    tick();
    tick();
    check("rst v_o", 32'(v_o), 32'd0);
    check("rst busy_o", 32'(busy_o), 32'd0);
    check("rst req_ready_o", 32'(req_ready_o), 32'd0);
    check("rst data_o", data_o, 32'd0);
    reset_i = 1'b0;
    tick();
    check_idle("post-rst");

    // Basic frame, ready always high; header must be valid the cycle after accept
    make_exp(BaseCfg);
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0;
    check("basic busy_o", 32'(busy_o), 32'd1);
    check("basic req_ready_o", 32'(req_ready_o), 32'd0);
    check("basic latency v_o", 32'(v_o), 32'd1);
    check("basic latency header", data_o, 32'h0B9A0004);
    collect("basic", 1'b0);
    check_idle("basic end");

    // Backpressure
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0;
    collect("bp", 1'b1);
    check_idle("bp end");

    // Snapshot: cfg change right after accept must not reach this frame
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0;
    cfg_i[64 +: 32] = 32'hDEADBEEF;
    collect("snap", 1'b0);
    make_exp({32'h88888888, 32'hDEADBEEF, 32'h22222222, 32'h11111111});
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0;
    collect("snap next", 1'b0);
    check_idle("snap end");

    // Reset after the 2nd payload word transfers
    cfg_i = BaseCfg;
    make_exp(BaseCfg);
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0;
    tick();  // header
    tick();  // payload 0
    tick();  // payload 1
    check("midrst pre v_o", 32'(v_o), 32'd1);
    check("midrst pre data_o", data_o, 32'h44444444);
    reset_i = 1'b1;
    tick();
    check("midrst v_o", 32'(v_o), 32'd0);
    check("midrst busy_o", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    tick();
    check_idle("midrst release");
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0;
    collect("post midrst", 1'b0);
    check_idle("post midrst end");

    // Request held high through a frame: exactly one follow-on frame
    req_v_i = 1'b1;
    tick();
    check("busy req_ready_o", 32'(req_ready_o), 32'd0);
    collect("busy first", 1'b0);
    check("busy re-ready", 32'(req_ready_o), 32'd1);
    check("busy gap busy_o", 32'(busy_o), 32'd0);
    tick();
    req_v_i = 1'b0;
    collect("busy second", 1'b0);
    check_idle("busy end");
    tick();
    check("busy no extra v_o", 32'(v_o), 32'd0);
    check("busy no extra busy_o", 32'(busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
